// File: rtl/ivector_heard_collector.sv
// Buffers heard(meth, v) events in a small FIFO and serializes each one as a header/payload beat pair.
// Optional per-method event counters are built when IVECTOR_HEARD_STATS_EN is defined.
module ivector_heard_collector #(
    parameter int DEPTH    = 4,
    parameter int NUM_METH = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        heard__ENA,
    input  logic [31:0] heard_meth,
    input  logic [31:0] heard_v,
    output logic        heard__RDY,
    output logic        ind_beat__ENA,
    output logic [31:0] ind_beat_data,
    output logic        ind_beat_last,
    input  logic        ind_beat__RDY,
    input  logic [3:0]  stat_sel,
    output logic [31:0] stat_count,
    input  logic        stat_clear__ENA
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    // err is resolved against the full 32-bit index at accept time.
    typedef struct packed {
        logic        err;
        logic [7:0]  meth;
        logic [31:0] v;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    state_t        state, state_next;
    logic [7:0]    seq;
    logic          full, empty, push, pop, err_in;
    logic          beat_ena, beat_last;
    logic [31:0]   beat_data;

    assign full   = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign empty  = (wr_ptr == rd_ptr);
    assign err_in = heard_meth >= 32'(NUM_METH);
    assign push   = heard__ENA & heard__RDY;
    assign head   = mem[rd_ptr[AW-1:0]];

    assign wr_ptr_next = wr_ptr + PW'(push);
    assign rd_ptr_next = rd_ptr + PW'(pop);

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{err: err_in, meth: heard_meth[7:0], v: heard_v};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
            seq    <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            state  <= state_next;
            if (pop) begin
                seq <= seq + 8'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        beat_ena   = 1'b0;
        beat_last  = 1'b0;
        beat_data  = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                beat_ena  = 1'b1;
                beat_data = {8'hE1, head.err, 7'b0, seq, head.meth};
                if (ind_beat__RDY) begin
                    state_next = PAY;
                end
            end
            PAY: begin
                beat_ena  = 1'b1;
                beat_last = 1'b1;
                beat_data = head.v;
                if (ind_beat__RDY) begin
                    pop        = 1'b1;
                    state_next = (wr_ptr_next != rd_ptr_next) ? HDR : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Nothing leaves the block while reset is held, whatever state the flops hold.
        if (!nRST) begin
            pop       = 1'b0;
            beat_ena  = 1'b0;
            beat_last = 1'b0;
            beat_data = '0;
        end
    end

    assign heard__RDY    = ~full & nRST;
    assign ind_beat__ENA = beat_ena;
    assign ind_beat_data = beat_data;
    assign ind_beat_last = beat_last;

`ifdef IVECTOR_HEARD_STATS_EN
    logic [31:0] cnt [NUM_METH];
    logic [31:0] bad;

    // A clear coinciding with an accept leaves the accepted method's counter at 1.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_METH; i++) begin
            if (!nRST) begin
                cnt[i] <= '0;
            end else if (push && heard_meth == 32'(i)) begin
                cnt[i] <= stat_clear__ENA ? 32'd1 : cnt[i] + 32'd1;
            end else if (stat_clear__ENA) begin
                cnt[i] <= '0;
            end
        end
        if (!nRST) begin
            bad <= '0;
        end else if (push && err_in) begin
            bad <= stat_clear__ENA ? 32'd1 : bad + 32'd1;
        end else if (stat_clear__ENA) begin
            bad <= '0;
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_METH; i++) begin
            if (stat_sel == 4'(i)) begin
                stat_count = cnt[i];
            end
        end
        if (stat_sel == 4'(NUM_METH)) begin
            stat_count = bad;
        end
    end
`else
    logic unused_stat;

    assign unused_stat = ^{stat_sel, stat_clear__ENA};
    assign stat_count  = '0;
`endif

endmodule
